// File: rtl/ip_tx_arbiter_if.sv
// Handshake bundle between the ICMP/UDP requesters, the IP TX framer and the MAC.
// The arbiter connects through the slave modport; the surrounding logic uses master.
interface ip_tx_arbiter_if;
    logic       icmp_tx_req;
    logic       icmp_tx_ready;
    logic [7:0] icmp_tx_data;
    logic       icmp_tx_ack;
    logic       icmp_data_req;
    logic       udp_tx_req;
    logic       udp_tx_ready;
    logic [7:0] udp_tx_data;
    logic       udp_tx_ack;
    logic       udp_data_req;
    logic       ip_tx_req;
    logic       ip_tx_ready;
    logic [7:0] ip_tx_data;
    logic [7:0] ip_tx_type;
    logic       ip_tx_ack;
    logic       ip_data_req;
    logic       mac_send_end;
    logic       arb_busy;
    logic       arb_timeout;

    modport slave (
        input  icmp_tx_req, icmp_tx_ready, icmp_tx_data,
        input  udp_tx_req, udp_tx_ready, udp_tx_data,
        input  ip_tx_ack, ip_data_req, mac_send_end,
        output icmp_tx_ack, icmp_data_req, udp_tx_ack, udp_data_req,
        output ip_tx_req, ip_tx_ready, ip_tx_data, ip_tx_type,
        output arb_busy, arb_timeout
    );

    modport master (
        output icmp_tx_req, icmp_tx_ready, icmp_tx_data,
        output udp_tx_req, udp_tx_ready, udp_tx_data,
        output ip_tx_ack, ip_data_req, mac_send_end,
        input  icmp_tx_ack, icmp_data_req, udp_tx_ack, udp_data_req,
        input  ip_tx_req, ip_tx_ready, ip_tx_data, ip_tx_type,
        input  arb_busy, arb_timeout
    );
endinterface

// File: rtl/ip_tx_arbiter.sv
// Two-way (ICMP/UDP) arbiter for the shared IP transmit path, round-robin by default.
// Define ARB_FIXED_PRIORITY_EN to make ICMP always win simultaneous requests.
module ip_tx_arbiter #(
    parameter logic [15:0] TIMEOUT_MAX = 16'hffff,
    parameter logic [7:0]  ICMP_PROTO  = 8'h01,
    parameter logic [7:0]  UDP_PROTO   = 8'h11
) (
    input logic             clk,
    input logic             rst_n,
    ip_tx_arbiter_if.slave  ip_tx_io
);

    typedef enum logic [2:0] {StIdle, StWaitAck, StAck, StXfer, StEnd} state_e;

    state_e      state_q, state_d;
    logic        gnt_q, gnt_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_d;
    logic        req_gnt, terminal, xfer;
    logic        ip_tx_req_q, icmp_ack_q, udp_ack_q, busy_q, tmo_q;
    logic [7:0]  type_q;
`ifdef ARB_FIXED_PRIORITY_EN
`else
    logic        last_gnt_q, last_gnt_d;
`endif

    assign req_gnt  = gnt_q ? ip_tx_io.udp_tx_req : ip_tx_io.icmp_tx_req;
    assign terminal = (cnt_q == TIMEOUT_MAX - 16'd1);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        tmo_d   = 1'b0;
`ifdef ARB_FIXED_PRIORITY_EN
`else
        last_gnt_d = last_gnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (ip_tx_io.icmp_tx_req || ip_tx_io.udp_tx_req) begin
`ifdef ARB_FIXED_PRIORITY_EN
                    gnt_d = ~ip_tx_io.icmp_tx_req;
`else
                    // On a tie, hand the path to whoever did not have it last.
                    gnt_d = (ip_tx_io.icmp_tx_req && ip_tx_io.udp_tx_req) ? ~last_gnt_q
                                                                         : ip_tx_io.udp_tx_req;
`endif
                    state_d = StWaitAck;
                end
            end
            StWaitAck: begin
                if (!req_gnt) begin
                    state_d = StIdle;
                end else if (ip_tx_io.ip_tx_ack) begin
                    state_d = StAck;
                end else if (terminal) begin
                    state_d = StIdle;
                    tmo_d   = 1'b1;
                end
            end
            StAck: begin
                state_d = StXfer;
`ifdef ARB_FIXED_PRIORITY_EN
`else
                last_gnt_d = gnt_q;
`endif
            end
            StXfer: begin
                if (ip_tx_io.mac_send_end) begin
                    state_d = StEnd;
                end else if (terminal) begin
                    state_d = StIdle;
                    tmo_d   = 1'b1;
                end
            end
            StEnd:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = 16'd0;
        end else if (state_q == StWaitAck || state_q == StXfer) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = 16'd0;
        end
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            gnt_q       <= 1'b0;
            cnt_q       <= 16'd0;
            ip_tx_req_q <= 1'b0;
            icmp_ack_q  <= 1'b0;
            udp_ack_q   <= 1'b0;
            busy_q      <= 1'b0;
            tmo_q       <= 1'b0;
            type_q      <= 8'h00;
`ifdef ARB_FIXED_PRIORITY_EN
`else
            last_gnt_q  <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            cnt_q       <= cnt_d;
            ip_tx_req_q <= (state_d == StWaitAck);
            icmp_ack_q  <= (state_d == StAck) && !gnt_d;
            udp_ack_q   <= (state_d == StAck) && gnt_d;
            busy_q      <= (state_d != StIdle);
            tmo_q       <= tmo_d;
            type_q      <= (state_d == StWaitAck || state_d == StXfer) ?
                           (gnt_d ? UDP_PROTO : ICMP_PROTO) : 8'h00;
`ifdef ARB_FIXED_PRIORITY_EN
`else
            last_gnt_q  <= last_gnt_d;
`endif
        end
    end

    assign xfer = (state_q == StXfer);

    assign ip_tx_io.ip_tx_req     = ip_tx_req_q;
    assign ip_tx_io.icmp_tx_ack   = icmp_ack_q;
    assign ip_tx_io.udp_tx_ack    = udp_ack_q;
    assign ip_tx_io.arb_busy      = busy_q;
    assign ip_tx_io.arb_timeout   = tmo_q;
    assign ip_tx_io.ip_tx_type    = type_q;
    assign ip_tx_io.ip_tx_ready   = xfer && (gnt_q ? ip_tx_io.udp_tx_ready : ip_tx_io.icmp_tx_ready);
    assign ip_tx_io.ip_tx_data    = !xfer ? 8'h00 :
                                    (gnt_q ? ip_tx_io.udp_tx_data : ip_tx_io.icmp_tx_data);
    assign ip_tx_io.icmp_data_req = xfer && !gnt_q && ip_tx_io.ip_data_req;
    assign ip_tx_io.udp_data_req  = xfer && gnt_q && ip_tx_io.ip_data_req;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed self-checking bench for ip_tx_arbiter with TIMEOUT_MAX = 16.
module tb_ip_tx_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    ip_tx_arbiter_if bus ();

    ip_tx_arbiter #(
        .TIMEOUT_MAX (16'd16),
        .ICMP_PROTO  (8'h01),
        .UDP_PROTO   (8'h11)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ip_tx_io (bus)
    );

    logic [23:0] outs;
    assign outs = {bus.icmp_tx_ack, bus.udp_tx_ack, bus.icmp_data_req, bus.udp_data_req,
                   bus.ip_tx_req, bus.ip_tx_ready, bus.ip_tx_data, bus.ip_tx_type,
                   bus.arb_busy, bus.arb_timeout};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.icmp_tx_req   = 1'b0;
        bus.icmp_tx_ready = 1'b0;
        bus.icmp_tx_data  = 8'h00;
        bus.udp_tx_req    = 1'b0;
        bus.udp_tx_ready  = 1'b0;
        bus.udp_tx_data   = 8'h00;
        bus.ip_tx_ack     = 1'b0;
        bus.ip_data_req   = 1'b0;
        bus.mac_send_end  = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        bus.ip_data_req   = 1'b1;
        bus.icmp_tx_ready = 1'b1;
        bus.icmp_tx_data  = 8'hFF;
        #3;
        checks++;
        if (outs !== 24'h0) begin
            failures++; $display("FAIL reset_outs: got %h want 000000", outs);
        end
        cyc(); cyc();
        checks++;
        if (outs !== 24'h0) begin
            failures++; $display("FAIL reset_hold: got %h want 000000", outs);
        end
        clear_inputs();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (bus.arb_busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle_busy: got %b want 0", bus.arb_busy);
        end
    endtask

    task automatic test_lone_icmp();
        bus.icmp_tx_req = 1'b1;
        cyc();
        checks++;
        if (bus.ip_tx_req !== 1'b1 || bus.ip_tx_type !== 8'h01 || bus.arb_busy !== 1'b1) begin
            failures++;
            $display("FAIL lone_grant: req=%b type=%h busy=%b want 1 01 1",
                     bus.ip_tx_req, bus.ip_tx_type, bus.arb_busy);
        end
        cyc(); cyc();
        checks++;
        if (bus.ip_tx_req !== 1'b1 || bus.icmp_tx_ack !== 1'b0) begin
            failures++;
            $display("FAIL lone_wait: req=%b ack=%b want 1 0", bus.ip_tx_req, bus.icmp_tx_ack);
        end
        bus.ip_tx_ack = 1'b1;
        cyc();
        checks++;
        if (bus.icmp_tx_ack !== 1'b1 || bus.udp_tx_ack !== 1'b0 || bus.ip_tx_req !== 1'b0
            || bus.ip_tx_type !== 8'h00) begin
            failures++;
            $display("FAIL lone_ack: icmp_ack=%b udp_ack=%b req=%b type=%h want 1 0 0 00",
                     bus.icmp_tx_ack, bus.udp_tx_ack, bus.ip_tx_req, bus.ip_tx_type);
        end
        bus.ip_tx_ack     = 1'b0;
        bus.icmp_tx_req   = 1'b0;
        bus.icmp_tx_ready = 1'b1;
        bus.icmp_tx_data  = 8'hAB;
        bus.ip_data_req   = 1'b1;
        cyc();
        checks++;
        if (bus.icmp_tx_ack !== 1'b0 || bus.ip_tx_data !== 8'hAB || bus.ip_tx_ready !== 1'b1
            || bus.icmp_data_req !== 1'b1 || bus.udp_data_req !== 1'b0
            || bus.ip_tx_type !== 8'h01) begin
            failures++;
            $display("FAIL lone_xfer: ack=%b data=%h rdy=%b idr=%b udr=%b type=%h want 0 ab 1 1 0 01",
                     bus.icmp_tx_ack, bus.ip_tx_data, bus.ip_tx_ready, bus.icmp_data_req,
                     bus.udp_data_req, bus.ip_tx_type);
        end
        bus.icmp_tx_data = 8'h5C;
        bus.ip_data_req  = 1'b0;
        #1;
        checks++;
        if (bus.ip_tx_data !== 8'h5C || bus.icmp_data_req !== 1'b0) begin
            failures++;
            $display("FAIL lone_zero_lag: data=%h idr=%b want 5c 0",
                     bus.ip_tx_data, bus.icmp_data_req);
        end
        bus.ip_data_req  = 1'b1;
        bus.mac_send_end = 1'b1;
        cyc();
        checks++;
        if (bus.arb_busy !== 1'b1 || bus.ip_tx_data !== 8'h00 || bus.icmp_data_req !== 1'b0
            || bus.ip_tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL lone_end: busy=%b data=%h idr=%b rdy=%b want 1 00 0 0",
                     bus.arb_busy, bus.ip_tx_data, bus.icmp_data_req, bus.ip_tx_ready);
        end
        clear_inputs();
        cyc();
        checks++;
        if (outs !== 24'h0) begin
            failures++; $display("FAIL lone_idle: got %h want 000000", outs);
        end
    endtask

    task automatic test_both();
        logic       exp_udp;
        logic [7:0] exp_type;
`ifdef ARB_FIXED_PRIORITY_EN
        exp_udp  = 1'b0;
        exp_type = 8'h01;
`else
        exp_udp  = 1'b1;
        exp_type = 8'h11;
`endif
        rst_n = 1'b0;
        bus.icmp_tx_req = 1'b1;
        bus.udp_tx_req  = 1'b1;
        cyc();
        rst_n = 1'b1;
        cyc();
        checks++;
        if (bus.ip_tx_req !== 1'b1 || bus.ip_tx_type !== 8'h01) begin
            failures++;
            $display("FAIL both_first: req=%b type=%h want 1 01", bus.ip_tx_req, bus.ip_tx_type);
        end
        bus.ip_tx_ack = 1'b1;
        cyc();
        checks++;
        if (bus.icmp_tx_ack !== 1'b1 || bus.udp_tx_ack !== 1'b0) begin
            failures++;
            $display("FAIL both_first_ack: icmp=%b udp=%b want 1 0",
                     bus.icmp_tx_ack, bus.udp_tx_ack);
        end
        bus.ip_tx_ack = 1'b0;
        cyc();
        bus.mac_send_end = 1'b1;
        cyc();
        bus.mac_send_end = 1'b0;
        checks++;
        if (bus.ip_tx_req !== 1'b0) begin
            failures++; $display("FAIL both_gap_end: req=%b want 0", bus.ip_tx_req);
        end
        cyc();
        checks++;
        if (bus.ip_tx_req !== 1'b0 || bus.arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL both_gap_idle: req=%b busy=%b want 0 0", bus.ip_tx_req, bus.arb_busy);
        end
        cyc();
        checks++;
        if (bus.ip_tx_req !== 1'b1 || bus.ip_tx_type !== exp_type) begin
            failures++;
            $display("FAIL both_second: req=%b type=%h want 1 %h",
                     bus.ip_tx_req, bus.ip_tx_type, exp_type);
        end
        bus.ip_tx_ack = 1'b1;
        cyc();
        checks++;
        if (bus.udp_tx_ack !== exp_udp || bus.icmp_tx_ack !== !exp_udp) begin
            failures++;
            $display("FAIL both_second_ack: udp=%b icmp=%b want %b %b",
                     bus.udp_tx_ack, bus.icmp_tx_ack, exp_udp, !exp_udp);
        end
        clear_inputs();
        cyc();
        bus.mac_send_end = 1'b1;
        cyc();
        bus.mac_send_end = 1'b0;
        cyc();
        checks++;
        if (bus.arb_busy !== 1'b0) begin
            failures++; $display("FAIL both_done: busy=%b want 0", bus.arb_busy);
        end
    endtask

    task automatic test_timeout();
        logic early;
        early = 1'b0;
        bus.udp_tx_req = 1'b1;
        cyc();
        for (int i = 1; i < 16; i++) begin
            cyc();
            if (bus.arb_timeout !== 1'b0 || bus.ip_tx_req !== 1'b1) early = 1'b1;
        end
        checks++;
        if (early) begin
            failures++; $display("FAIL timeout_early: got early abort want none before 16");
        end
        cyc();
        bus.udp_tx_req = 1'b0;
        checks++;
        if (bus.arb_timeout !== 1'b1 || bus.ip_tx_req !== 1'b0 || bus.arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout_pulse: tmo=%b req=%b busy=%b want 1 0 0",
                     bus.arb_timeout, bus.ip_tx_req, bus.arb_busy);
        end
        cyc();
        checks++;
        if (bus.arb_timeout !== 1'b0 || bus.arb_busy !== 1'b0 || bus.udp_tx_ack !== 1'b0) begin
            failures++;
            $display("FAIL timeout_once: tmo=%b busy=%b ack=%b want 0 0 0",
                     bus.arb_timeout, bus.arb_busy, bus.udp_tx_ack);
        end
    endtask

    task automatic test_withdraw();
        bus.udp_tx_req = 1'b1;
        cyc();
        checks++;
        if (bus.ip_tx_req !== 1'b1 || bus.ip_tx_type !== 8'h11) begin
            failures++;
            $display("FAIL withdraw_grant: req=%b type=%h want 1 11", bus.ip_tx_req, bus.ip_tx_type);
        end
        bus.udp_tx_req = 1'b0;
        cyc();
        checks++;
        if (bus.ip_tx_req !== 1'b0 || bus.udp_tx_ack !== 1'b0 || bus.arb_timeout !== 1'b0
            || bus.arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL withdraw_drop: req=%b ack=%b tmo=%b busy=%b want 0 0 0 0",
                     bus.ip_tx_req, bus.udp_tx_ack, bus.arb_timeout, bus.arb_busy);
        end
        cyc();
        checks++;
        if (outs !== 24'h0) begin
            failures++; $display("FAIL withdraw_quiet: got %h want 000000", outs);
        end
    endtask

    task automatic test_end_vs_timeout();
        logic bad;
        bad = 1'b0;
        bus.icmp_tx_req = 1'b1;
        cyc();
        bus.ip_tx_ack = 1'b1;
        cyc();
        bus.ip_tx_ack   = 1'b0;
        bus.icmp_tx_req = 1'b0;
        cyc();
        for (int i = 1; i < 16; i++) begin
            cyc();
            if (bus.ip_tx_type !== 8'h01 || bus.arb_timeout !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++; $display("FAIL xfer_hold: left XFER early want 15 cycles held");
        end
        bus.mac_send_end = 1'b1;
        cyc();
        bus.mac_send_end = 1'b0;
        checks++;
        if (bus.arb_timeout !== 1'b0 || bus.arb_busy !== 1'b1 || bus.ip_tx_type !== 8'h00) begin
            failures++;
            $display("FAIL end_wins: tmo=%b busy=%b type=%h want 0 1 00",
                     bus.arb_timeout, bus.arb_busy, bus.ip_tx_type);
        end
        cyc();
        checks++;
        if (bus.arb_timeout !== 1'b0 || bus.arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL end_wins_idle: tmo=%b busy=%b want 0 0", bus.arb_timeout, bus.arb_busy);
        end
    endtask

    task automatic test_reset_mid_xfer();
        bus.icmp_tx_req = 1'b1;
        cyc();
        bus.ip_tx_ack = 1'b1;
        cyc();
        bus.ip_tx_ack     = 1'b0;
        bus.icmp_tx_ready = 1'b1;
        bus.icmp_tx_data  = 8'hAB;
        bus.ip_data_req   = 1'b1;
        cyc();
        checks++;
        if (bus.ip_tx_ready !== 1'b1 || bus.icmp_data_req !== 1'b1) begin
            failures++;
            $display("FAIL rstx_pre: rdy=%b idr=%b want 1 1", bus.ip_tx_ready, bus.icmp_data_req);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== 24'h0) begin
            failures++; $display("FAIL rstx_async: got %h want 000000", outs);
        end
        cyc();
        rst_n = 1'b1;
        bus.icmp_tx_ready = 1'b0;
        bus.ip_data_req   = 1'b0;
        checks++;
        if (bus.icmp_tx_ack !== 1'b0 || bus.arb_busy !== 1'b0) begin
            failures++;
            $display("FAIL rstx_noreplay: ack=%b busy=%b want 0 0", bus.icmp_tx_ack, bus.arb_busy);
        end
        cyc();
        checks++;
        if (bus.ip_tx_req !== 1'b1 || bus.ip_tx_type !== 8'h01) begin
            failures++;
            $display("FAIL rstx_regrant: req=%b type=%h want 1 01", bus.ip_tx_req, bus.ip_tx_type);
        end
        bus.ip_tx_ack = 1'b1;
        cyc();
        checks++;
        if (bus.icmp_tx_ack !== 1'b1) begin
            failures++; $display("FAIL rstx_ack: got %b want 1", bus.icmp_tx_ack);
        end
        clear_inputs();
        cyc();
        bus.mac_send_end = 1'b1;
        cyc();
        bus.mac_send_end = 1'b0;
        cyc();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_lone_icmp();
        test_both();
        test_timeout();
        test_withdraw();
        test_end_vs_timeout();
        test_reset_mid_xfer();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
